// File: rtl/frame_tx_8b10b_mopshub_pkg.sv
// ---------------------------------------------------------------------------
// frame_tx_mopshub_pkg
// Shared definitions for the MOPS-Hub 8b10b frame transmitter:
//   - FSM state encoding (CRC state present only with FRAME_TX_CRC8_EN)
//   - K28.x control symbol bytes handed to the 8b10b encoder
//   - CRC-8 generator polynomial (x^8 + x^2 + x + 1)
// Optional feature macro: FRAME_TX_CRC8_EN
// ---------------------------------------------------------------------------
package frame_tx_mopshub_pkg;

  // ST_SOP names the start-of-packet step for readability; the SOP symbol
  // itself is emitted on the IDLE->DATA transition tick, so the encoding is
  // never held as a register value.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOP  = 3'd1,
    ST_DATA = 3'd2,
`ifdef FRAME_TX_CRC8_EN
    ST_CRC  = 3'd3,
`endif
    ST_EOP  = 3'd4,
    ST_DROP = 3'd5
  } state_t;

  localparam logic [7:0] K28_0 = 8'h1C;  // FILL
  localparam logic [7:0] K28_1 = 8'h3C;  // SOP
  localparam logic [7:0] K28_5 = 8'hBC;  // IDLE / comma
  localparam logic [7:0] K28_6 = 8'hDC;  // EOP

  localparam logic [7:0] CRC8_POLY = 8'h07;

endpackage

// File: rtl/frame_tx_8b10b_mopshub_if.sv
// ---------------------------------------------------------------------------
// frame_tx_8b10b_mopshub_if
// Payload byte stream into the frame transmitter.
//   tx_valid : byte valid                (master -> slave)
//   tx_data  : payload byte              (master -> slave)
//   tx_last  : final byte of the frame   (master -> slave)
//   tx_ready : byte taken when valid & ready (slave -> master)
// ---------------------------------------------------------------------------
interface frame_tx_8b10b_mopshub_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;

  modport master (output tx_valid, output tx_data, output tx_last, input tx_ready);
  modport slave  (input tx_valid, input tx_data, input tx_last, output tx_ready);
endinterface

// File: rtl/frame_tx_8b10b_mopshub_crc8.sv
// ---------------------------------------------------------------------------
// crc8_mopshub
// Combinational byte-wide CRC-8 step: poly 0x07, MSB first, no reflection.
//   i_crc  : current CRC register value
//   i_data : payload byte folded in
//   o_crc  : CRC after the byte
// Only instantiated when FRAME_TX_CRC8_EN is defined.
// ---------------------------------------------------------------------------
module crc8_mopshub
  import frame_tx_mopshub_pkg::*;
(
  input  logic [7:0] i_crc,
  input  logic [7:0] i_data,
  output logic [7:0] o_crc
);

  logic [7:0] w_c;
  logic       w_fb;

  always_comb begin
    w_c  = i_crc;
    w_fb = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      w_fb = w_c[7] ^ i_data[i];
      w_c  = {w_c[6:0], 1'b0} ^ (w_fb ? CRC8_POLY : 8'h00);
    end
  end

  assign o_crc = w_c;

endmodule

// File: rtl/frame_tx_8b10b_mopshub.sv
// ---------------------------------------------------------------------------
// frame_tx_8b10b_mopshub
// Frames a payload byte stream into 8b10b encoder symbols, one symbol per
// sym_tick: IDLE (K28.5) filler, SOP (K28.1), data bytes, optional CRC-8,
// EOP (K28.6). FILL (K28.0) is inserted when the source starves mid-frame.
// Frames longer than MAX_LEN are closed early and the remainder discarded.
//
// Parameters: MAX_LEN (1..255) max payload bytes, IDLE_MIN (1..15) minimum
//             idle symbols between frames.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   sym_tick     : symbol strobe
//   tx           : payload stream (slave side of frame_tx_8b10b_mopshub_if)
//   enc_ena/ki/data : symbol to the encoder, registered one cycle after tick
//   tx_underrun  : pulse with an emitted FILL symbol
//   tx_trunc     : pulse with the data byte that hit MAX_LEN
//   busy         : FSM not in IDLE
// Optional feature macro: FRAME_TX_CRC8_EN (adds the CRC-8 byte before EOP).
// ---------------------------------------------------------------------------
module frame_tx_8b10b_mopshub
  import frame_tx_mopshub_pkg::*;
#(
  parameter int MAX_LEN  = 16,
  parameter int IDLE_MIN = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sym_tick,
  frame_tx_8b10b_mopshub_if.slave       tx,
  output logic                          enc_ena,
  output logic                          enc_ki,
  output logic [7:0]                    enc_data,
  output logic                          tx_underrun,
  output logic                          tx_trunc,
  output logic                          busy
);

  localparam logic [3:0] IDLE_MIN_L = 4'(IDLE_MIN);
  localparam logic [7:0] MAX_LEN_L  = 8'(MAX_LEN);

`ifdef FRAME_TX_CRC8_EN
  localparam state_t ST_CLOSE = ST_CRC;
`else
  localparam state_t ST_CLOSE = ST_EOP;
`endif

  state_t     r_state, w_state_nxt;
  logic [3:0] r_idle_cnt, w_idle_nxt;
  logic [7:0] r_byte_cnt, w_cnt_nxt;
  logic       r_trunc_pend, w_pend_nxt;   // frame was cut: EOP leads to DROP
  logic       r_enc_ena, r_enc_ki, r_underrun, r_trunc;
  logic [7:0] r_enc_data;
  logic       w_sym_ki, w_und, w_trn;
  logic [7:0] w_sym_data;
  logic       w_ready, w_acc;

`ifdef FRAME_TX_CRC8_EN
  logic [7:0] r_crc, w_crc_nxt, w_crc_upd;

  crc8_mopshub u_crc (
    .i_crc  (r_crc),
    .i_data (tx.tx_data),
    .o_crc  (w_crc_upd)
  );
`endif

  // Ready depends only on state and the tick so the source may not build a
  // combinational loop through tx_valid.
  assign w_ready     = ((r_state == ST_DATA) && sym_tick) || (r_state == ST_DROP);
  assign w_acc       = tx.tx_valid && w_ready;
  assign tx.tx_ready = w_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_idle_nxt  = r_idle_cnt;
    w_cnt_nxt   = r_byte_cnt;
    w_pend_nxt  = r_trunc_pend;
    w_sym_ki    = 1'b1;
    w_sym_data  = K28_5;
    w_und       = 1'b0;
    w_trn       = 1'b0;
`ifdef FRAME_TX_CRC8_EN
    w_crc_nxt   = r_crc;
`endif
    case (r_state)
      ST_IDLE: if (sym_tick) begin
        if (tx.tx_valid && (r_idle_cnt >= IDLE_MIN_L)) begin
          // SOP only announces the frame; the first byte is taken next tick.
          w_sym_data  = K28_1;
          w_cnt_nxt   = 8'd0;
          w_pend_nxt  = 1'b0;
`ifdef FRAME_TX_CRC8_EN
          w_crc_nxt   = 8'h00;
`endif
          w_state_nxt = ST_DATA;
        end else begin
          w_idle_nxt = (r_idle_cnt == 4'hF) ? 4'hF : r_idle_cnt + 4'd1;
        end
      end
      ST_DATA: if (sym_tick) begin
        if (tx.tx_valid) begin
          w_sym_ki   = 1'b0;
          w_sym_data = tx.tx_data;
          w_cnt_nxt  = r_byte_cnt + 8'd1;
`ifdef FRAME_TX_CRC8_EN
          w_crc_nxt  = w_crc_upd;
`endif
          if (tx.tx_last) begin
            w_state_nxt = ST_CLOSE;
          end else if (w_cnt_nxt == MAX_LEN_L) begin
            w_trn       = 1'b1;
            w_pend_nxt  = 1'b1;
            w_state_nxt = ST_CLOSE;
          end
        end else begin
          w_sym_data = K28_0;
          w_und      = 1'b1;
        end
      end
`ifdef FRAME_TX_CRC8_EN
      ST_CRC: if (sym_tick) begin
        w_sym_ki    = 1'b0;
        w_sym_data  = r_crc;
        w_state_nxt = ST_EOP;
      end
`endif
      ST_EOP: if (sym_tick) begin
        w_sym_data  = K28_6;
        w_idle_nxt  = 4'd0;
        w_pend_nxt  = 1'b0;
        w_state_nxt = r_trunc_pend ? ST_DROP : ST_IDLE;
      end
      ST_DROP: begin
        // Idle symbols go out while the rest of the cut frame is drained.
        if (sym_tick)
          w_idle_nxt = (r_idle_cnt == 4'hF) ? 4'hF : r_idle_cnt + 4'd1;
        if (w_acc && tx.tx_last)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_idle_cnt   <= 4'd0;
      r_byte_cnt   <= 8'd0;
      r_trunc_pend <= 1'b0;
      r_enc_ena    <= 1'b0;
      r_enc_ki     <= 1'b1;
      r_enc_data   <= K28_5;
      r_underrun   <= 1'b0;
      r_trunc      <= 1'b0;
`ifdef FRAME_TX_CRC8_EN
      r_crc        <= 8'h00;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_idle_cnt   <= w_idle_nxt;
      r_byte_cnt   <= w_cnt_nxt;
      r_trunc_pend <= w_pend_nxt;
      r_enc_ena    <= sym_tick;
      r_underrun   <= w_und;
      r_trunc      <= w_trn;
      if (sym_tick) begin
        r_enc_ki   <= w_sym_ki;
        r_enc_data <= w_sym_data;
      end
`ifdef FRAME_TX_CRC8_EN
      r_crc        <= w_crc_nxt;
`endif
    end
  end

  assign enc_ena     = r_enc_ena;
  assign enc_ki      = r_enc_ki;
  assign enc_data    = r_enc_data;
  assign tx_underrun = r_underrun;
  assign tx_trunc    = r_trunc;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_frame_tx_8b10b_mopshub.sv
// ---------------------------------------------------------------------------
// tb_frame_tx_8b10b_mopshub
// Directed cycle table for the listed scenarios, then a randomized run whose
// symbol stream is parsed frame by frame against the offered payload.
// DUT built with MAX_LEN=2, IDLE_MIN=2. Honors FRAME_TX_CRC8_EN.
// ---------------------------------------------------------------------------
module tb_frame_tx_8b10b_mopshub;

  localparam int MAXL = 2;
  localparam int IMIN = 2;

  logic clk = 1'b0;
  logic rst, sym_tick;
  logic enc_ena, enc_ki, tx_underrun, tx_trunc, busy;
  logic [7:0] enc_data;

  frame_tx_8b10b_mopshub_if u_if ();

  frame_tx_8b10b_mopshub #(.MAX_LEN(MAXL), .IDLE_MIN(IMIN)) dut (
    .clk         (clk),
    .rst         (rst),
    .sym_tick    (sym_tick),
    .tx          (u_if),
    .enc_ena     (enc_ena),
    .enc_ki      (enc_ki),
    .enc_data    (enc_data),
    .tx_underrun (tx_underrun),
    .tx_trunc    (tx_trunc),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // CRC-8 as the remainder of M(x)*x^8 divided by x^8+x^2+x+1.
  function automatic logic [7:0] crc_ref(input logic [7:0] q[$]);
    logic [8:0] rem;
    rem = 9'h000;
    for (int i = 0; i < q.size() + 1; i++) begin
      for (int b = 7; b >= 0; b--) begin
        logic [7:0] cur;
        cur = (i < q.size()) ? q[i] : 8'h00;
        rem = {rem[7:0], cur[b]};
        if (rem[8]) rem = rem ^ 9'h107;
      end
    end
    return rem[7:0];
  endfunction

  typedef struct {
    bit         rst, tick, vld;
    logic [7:0] dat;
    bit         lst;
    bit         x_rdy, x_ena, x_ki;
    logic [7:0] x_dat;
    bit         x_und, x_trn, x_busy;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input bit r, input bit t, input bit v, input logic [7:0] d, input bit l,
                     input bit xr, input bit xe, input bit xk, input logic [7:0] xd,
                     input bit xu, input bit xt, input bit xb);
    vec_t e;
    e = '{r, t, v, d, l, xr, xe, xk, xd, xu, xt, xb};
    tbl.push_back(e);
  endtask

  typedef struct { logic ki; logic [7:0] d; logic u, t; } sym_t;
  sym_t       syms[$];
  logic [7:0] src_b[$];
  bit         src_l[$];
  int         flens[$];

  function automatic sym_t get_sym(input int i);
    sym_t s;
    s = '{1'b0, 8'h00, 1'b0, 1'b0};
    if (i < syms.size()) s = syms[i];
    return s;
  endfunction

  task automatic check_stream();
    int   idx, idles, bpos, got, ne, L;
    bit   tr;
    sym_t s;
    logic [7:0] pay[$];
    idx = 0; idles = 0; bpos = 0;
    for (int f = 0; f < flens.size(); f++) begin
      L  = flens[f];
      ne = (L > MAXL) ? MAXL : L;
      tr = (L > MAXL);
      pay.delete();
      while (idx < syms.size() && syms[idx].ki && syms[idx].d == 8'hBC) begin
        idles++; idx++;
      end
      s = get_sym(idx); idx++;
      chk("rand_sop", {s.ki, s.d}, {1'b1, 8'h3C});
      chk("rand_idle_gap", 32'(idles >= IMIN), 32'd1);
      got = 0;
      while (got < ne && idx < syms.size()) begin
        s = syms[idx]; idx++;
        if (s.ki) chk("rand_fill", {s.d, s.u, s.t}, {8'h1C, 1'b1, 1'b0});
        else begin
          pay.push_back(src_b[bpos + got]);
          chk("rand_data", {s.d, s.u, s.t}, {src_b[bpos + got], 1'b0, (tr && got == ne - 1)});
          got++;
        end
      end
      chk("rand_payload_len", got, ne);
`ifdef FRAME_TX_CRC8_EN
      s = get_sym(idx); idx++;
      chk("rand_crc", {s.ki, s.d}, {1'b0, crc_ref(pay)});
`endif
      s = get_sym(idx); idx++;
      chk("rand_eop", {s.ki, s.d}, {1'b1, 8'hDC});
      bpos += L;
      idles = 0;
    end
    got = 0;
    for (int i = idx; i < syms.size(); i++)
      if (!(syms[i].ki && syms[i].d == 8'hBC)) got++;
    chk("rand_trailing_idle", got, 0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] c_a, c_b, c_c, c_d;
    int   gap, bi, quiet, cyc;
    bit   acc, prev_tick;

    rst = 1'b1; sym_tick = 1'b0;
    u_if.tx_valid = 1'b0; u_if.tx_data = 8'h00; u_if.tx_last = 1'b0;

    q = '{8'hA5, 8'h5A}; c_a = crc_ref(q);
    q = '{8'h01};        c_b = crc_ref(q);
    q = '{8'h10, 8'h11}; c_c = crc_ref(q);
    q = '{8'h21};        c_d = crc_ref(q);
    chk("crc_ref_0x01", c_b, 8'h07);

    //   rst t v dat   l   rdy ena ki dat   und trn busy
    row(1, 0, 0, 8'h00, 0,  0, 0, 1, 8'hBC, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      row(0, 1, 0, 8'h00, 0,  0, 1, 1, 8'hBC, 0, 0, 0);
    // underrun frame after exactly IDLE_MIN idles
    row(1, 0, 0, 8'h00, 0,  0, 0, 1, 8'hBC, 0, 0, 0);
    row(0, 1, 1, 8'hA5, 0,  0, 1, 1, 8'hBC, 0, 0, 0);
    row(0, 1, 1, 8'hA5, 0,  0, 1, 1, 8'hBC, 0, 0, 0);
    row(0, 1, 1, 8'hA5, 0,  0, 1, 1, 8'h3C, 0, 0, 1);
    row(0, 1, 1, 8'hA5, 0,  1, 1, 0, 8'hA5, 0, 0, 1);
    row(0, 1, 0, 8'h00, 0,  1, 1, 1, 8'h1C, 1, 0, 1);
    row(0, 1, 1, 8'h5A, 1,  1, 1, 0, 8'h5A, 0, 0, 1);
`ifdef FRAME_TX_CRC8_EN
    row(0, 1, 0, 8'h00, 0,  0, 1, 0, c_a,   0, 0, 1);
`endif
    row(0, 1, 0, 8'h00, 0,  0, 1, 1, 8'hDC, 0, 0, 0);
    // single-byte frame with a tick-less cycle in the middle
    row(0, 1, 0, 8'h00, 0,  0, 1, 1, 8'hBC, 0, 0, 0);
    row(0, 0, 1, 8'h01, 1,  0, 0, 1, 8'hBC, 0, 0, 0);
    row(0, 1, 1, 8'h01, 1,  0, 1, 1, 8'hBC, 0, 0, 0);
    row(0, 1, 1, 8'h01, 1,  0, 1, 1, 8'h3C, 0, 0, 1);
    row(0, 0, 1, 8'h01, 1,  0, 0, 1, 8'h3C, 0, 0, 1);
    row(0, 1, 1, 8'h01, 1,  1, 1, 0, 8'h01, 0, 0, 1);
`ifdef FRAME_TX_CRC8_EN
    row(0, 1, 0, 8'h00, 0,  0, 1, 0, c_b,   0, 0, 1);
`endif
    row(0, 1, 0, 8'h00, 0,  0, 1, 1, 8'hDC, 0, 0, 0);
    // truncation at MAX_LEN=2, then drop 0x12/0x13
    row(0, 1, 0, 8'h00, 0,  0, 1, 1, 8'hBC, 0, 0, 0);
    row(0, 1, 0, 8'h00, 0,  0, 1, 1, 8'hBC, 0, 0, 0);
    row(0, 1, 1, 8'h10, 0,  0, 1, 1, 8'h3C, 0, 0, 1);
    row(0, 1, 1, 8'h10, 0,  1, 1, 0, 8'h10, 0, 0, 1);
    row(0, 1, 1, 8'h11, 0,  1, 1, 0, 8'h11, 0, 1, 1);
`ifdef FRAME_TX_CRC8_EN
    row(0, 1, 1, 8'h12, 0,  0, 1, 0, c_c,   0, 0, 1);
`endif
    row(0, 1, 1, 8'h12, 0,  0, 1, 1, 8'hDC, 0, 0, 1);
    row(0, 0, 1, 8'h12, 0,  1, 0, 1, 8'hDC, 0, 0, 1);
    row(0, 1, 1, 8'h13, 1,  1, 1, 1, 8'hBC, 0, 0, 0);
    row(0, 1, 1, 8'h20, 0,  0, 1, 1, 8'hBC, 0, 0, 0);
    row(0, 1, 1, 8'h20, 0,  0, 1, 1, 8'h3C, 0, 0, 1);
    row(0, 1, 1, 8'h20, 0,  1, 1, 0, 8'h20, 0, 0, 1);
    // reset mid-DATA abandons the frame
    row(1, 1, 1, 8'h21, 0,  1, 0, 1, 8'hBC, 0, 0, 0);
    row(0, 1, 1, 8'h21, 0,  0, 1, 1, 8'hBC, 0, 0, 0);
    row(0, 1, 1, 8'h21, 0,  0, 1, 1, 8'hBC, 0, 0, 0);
    row(0, 1, 1, 8'h21, 0,  0, 1, 1, 8'h3C, 0, 0, 1);
    row(0, 1, 1, 8'h21, 1,  1, 1, 0, 8'h21, 0, 0, 1);
`ifdef FRAME_TX_CRC8_EN
    row(0, 1, 0, 8'h00, 0,  0, 1, 0, c_d,   0, 0, 1);
`endif
    row(0, 1, 0, 8'h00, 0,  0, 1, 1, 8'hDC, 0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; sym_tick = tbl[i].tick;
      u_if.tx_valid = tbl[i].vld; u_if.tx_data = tbl[i].dat; u_if.tx_last = tbl[i].lst;
      #1;
      chk($sformatf("vec%0d_ready", i), u_if.tx_ready, tbl[i].x_rdy);
      @(negedge clk);
      chk($sformatf("vec%0d_out", i), {enc_ena, enc_ki, enc_data, tx_underrun, tx_trunc, busy},
          {tbl[i].x_ena, tbl[i].x_ki, tbl[i].x_dat, tbl[i].x_und, tbl[i].x_trn, tbl[i].x_busy});
    end

    // ---------------- randomized run ----------------
    for (int f = 0; f < 80; f++) begin
      int L;
      L = $urandom_range(1, 4);
      flens.push_back(L);
      for (int b = 0; b < L; b++) begin
        src_b.push_back(8'($urandom));
        src_l.push_back(b == L - 1);
      end
    end
    rst = 1'b1; sym_tick = 1'b0; u_if.tx_valid = 1'b0; u_if.tx_last = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    gap = 0; bi = 0; quiet = 0; cyc = 0; acc = 0; prev_tick = 0;
    while (cyc < 40000 && quiet < 8) begin
      case ((cyc / 400) % 3)
        0:       sym_tick = 1'b1;
        1:       sym_tick = (cyc % 4 == 0);
        default: sym_tick = 1'($urandom_range(0, 1));
      endcase
      if (bi < src_b.size() && gap == 0) begin
        u_if.tx_valid = 1'b1; u_if.tx_data = src_b[bi]; u_if.tx_last = src_l[bi];
      end else begin
        u_if.tx_valid = 1'b0;
        if (gap > 0) gap--;
      end
      #1;
      acc = u_if.tx_valid && u_if.tx_ready;
      prev_tick = sym_tick;
      @(negedge clk);
      cyc++;
      chk("rand_ena_latency", enc_ena, prev_tick);
      if (enc_ena) syms.push_back('{enc_ki, enc_data, tx_underrun, tx_trunc});
      else chk("rand_pulse_without_ena", {tx_underrun, tx_trunc}, 2'b00);
      if (acc) begin
        bi++;
        gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      end
      if (bi == src_b.size() && !busy) quiet++;
      else quiet = 0;
    end
    chk("rand_run_completed", 32'(quiet >= 8), 32'd1);
    check_stream();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_tx_8b10b_mopshub.md
FRAME_TX_8B10B_MOPSHUB -- requirements
Module: frame_tx_8b10b_mopshub

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, maximum payload bytes per frame (1..255).
REQ-002 SHALL have parameter IDLE_MIN, default 2, minimum idle symbols between frames (1..15).
REQ-003 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port sym_tick  in  1  one-cycle strobe; one symbol is emitted per strobe.
REQ-006 SHALL have port tx_valid  in  1  payload byte valid.
REQ-007 SHALL have port tx_data  in  8  payload byte.
REQ-008 SHALL have port tx_last  in  1  final byte of frame, qualified by tx_valid.
REQ-009 SHALL have port tx_ready  out  1  byte accepted when tx_valid & tx_ready.
REQ-010 SHALL have port enc_ena  out  1  symbol strobe to the 8b10b encoder.
REQ-011 SHALL have port enc_ki  out  1  control-symbol flag to the encoder.
REQ-012 SHALL have port enc_data  out  8  symbol byte to the encoder.
REQ-013 SHALL have port tx_underrun  out  1  one-cycle pulse: fill symbol inserted mid-frame.
REQ-014 SHALL have port tx_trunc  out  1  one-cycle pulse: frame cut at MAX_LEN.
REQ-015 SHALL have port busy  out  1  high in any state except IDLE.

Function
REQ-016 Symbols: IDLE = K28.5 (ki=1, 0xBC); SOP = K28.1 (0x3C); EOP = K28.6 (0xDC); FILL = K28.0 (0x1C); data/CRC bytes ki=0.
REQ-017 Latency: a symbol selected in the cycle with sym_tick=1 SHALL appear on enc_ki/enc_data in the next cycle, with enc_ena=1 for exactly that one cycle; otherwise enc_ena=0 and enc_ki/enc_data hold.
REQ-018 States: IDLE, SOP, DATA, CRC, EOP, DROP.
REQ-019 IDLE: each tick emits IDLE and saturating-increments idle_cnt; on a tick with tx_valid=1 and idle_cnt>=IDLE_MIN, emit SOP instead, clear byte count and CRC, go DATA; no byte is consumed.
REQ-020 tx_ready SHALL equal sym_tick & (state==DATA), or 1 in DROP; combinational from state and sym_tick only, never from tx_valid.
REQ-021 DATA tick with tx_valid=1: emit tx_data, update CRC, increment byte count; if tx_last go CRC (macro on) or EOP (macro off).
REQ-022 DATA tick with tx_valid=0: emit FILL, pulse tx_underrun, stay in DATA; byte count unchanged.
REQ-023 Byte accepted with count reaching MAX_LEN and tx_last=0: pulse tx_trunc, close the frame normally (CRC/EOP), then enter DROP instead of IDLE.
REQ-024 DROP: accept and discard bytes every cycle; ticks emit IDLE; leave to IDLE on accepted tx_last; idle_cnt counts in DROP.
REQ-025 CRC tick: emit CRC byte, ki=0, go EOP. EOP tick: emit EOP, clear idle_cnt, go IDLE or DROP per REQ-023.
REQ-026 Zero-length frames are impossible; SOP always followed by >=1 data or FILL symbol.

Reset
REQ-027 rst in any state SHALL force IDLE within one cycle, abandoning any frame without EOP.
REQ-028 Reset values: enc_ena 0, enc_ki 1, enc_data 0xBC, tx_underrun 0, tx_trunc 0, busy 0, idle_cnt 0, byte count 0, CRC 0x00.

Configuration
REQ-029 Macro FRAME_TX_CRC8_EN defined: CRC state used; CRC-8, poly 0x07, init 0x00, MSB-first, no final XOR, over payload bytes only, sent between last data byte and EOP.
REQ-030 FRAME_TX_CRC8_EN undefined: no CRC logic or state; DATA goes directly to EOP.

Structure
REQ-031 Package frame_tx_mopshub_pkg SHALL hold the state enum, symbol constants (K28_0/1/5/6), and CRC8 polynomial.
REQ-032 Byte-wide CRC-8 next-value function SHALL be sub-module crc8_mopshub (combinational), instantiated only under FRAME_TX_CRC8_EN.

Verification
REQ-033 sym_tick every cycle, no tx_valid, 5 ticks -> 5 consecutive enc_ena pulses with ki=1, data 0xBC.
REQ-034 CRC on, frame {0x01, last} after 2 idles -> 0x3C(k), 0x01, 0x07, 0xDC(k), then 0xBC.
REQ-035 CRC off, frame {0xA5,0x5A last}, tx_valid low one tick mid-frame -> 0x3C(k), 0xA5, 0x1C(k) with tx_underrun pulse, 0x5A, 0xDC(k).
REQ-036 MAX_LEN=2, 4-byte frame 0x10..0x13 -> 0x10, 0x11, tx_trunc pulse, EOP; 0x12,0x13 dropped; next frame waits IDLE_MIN idles.
REQ-037 rst asserted mid-DATA -> next cycle outputs at REQ-028 values; next frame starts with SOP only after IDLE_MIN idle ticks.
REQ-038 sym_tick every 4th cycle -> enc_ena pulses exactly 1 cycle after each tick; tx_ready high only in tick cycles during DATA.
